// File: rtl/barrett_ds_issuer.sv
// barrett_ds_issuer
//   Initiator-side controller for the digit-serial Barrett reducer (barrett_ds).
//   It takes operands x from a valid/ready stream and issues one reduction at a time:
//   it pulses start, waits for the reducer's valid, and holds the result on a
//   valid/ready output stream until the result is accepted.
//   A zero operand bypasses the reducer. A per-job watchdog aborts jobs whose
//   reducer never answers. The module counts the results accepted downstream.
//
// Ports
//   CLK_pci_sys_clk_p  clock, rising edge
//   rst_i              asynchronous active-high reset
//   in_valid_i/in_ready_o/in_x_i         operand stream
//   red_start_o/red_x_o                  start pulse and operand to the reducer
//   red_q_o/red_q_bl_o/red_mu_o          constant modulus, bit length and Barrett mu
//   red_result_i/red_valid_i             reducer result and finish pulse
//   out_valid_o/out_ready_i/out_r_o      result stream (x mod q)
//   timeout_o                            sticky: a job was aborted by the watchdog
//   job_count_o                          results accepted downstream (wraps)
module barrett_ds_issuer #(
    parameter int unsigned DATA_LENGTH    = 64,
    parameter int unsigned MODULUS        = 8380417,
    parameter int unsigned MODULUS_LENGTH = 23,
    parameter int unsigned MU             = 8396807,
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                   CLK_pci_sys_clk_p,
    input  logic                   rst_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [DATA_LENGTH-1:0] in_x_i,
    output logic                   red_start_o,
    output logic [DATA_LENGTH-1:0] red_x_o,
    output logic [DATA_LENGTH-1:0] red_q_o,
    output logic [DATA_LENGTH-1:0] red_q_bl_o,
    output logic [DATA_LENGTH-1:0] red_mu_o,
    input  logic [DATA_LENGTH-1:0] red_result_i,
    input  logic                   red_valid_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [DATA_LENGTH-1:0] out_r_o,
    output logic                   timeout_o,
    output logic [CNT_WIDTH-1:0]   job_count_o
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StStart = 2'd1;
    localparam logic [1:0] StWait  = 2'd2;
    localparam logic [1:0] StHold  = 2'd3;

    localparam int unsigned         WdWidth = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WdWidth-1:0]  WdLast  = WdWidth'(TIMEOUT_CYCLES - 1);

    logic [1:0]             state_q, state_d;
    logic [DATA_LENGTH-1:0] x_q, x_d;
    logic [DATA_LENGTH-1:0] r_q, r_d;
    logic                   out_valid_q, out_valid_d;
    logic                   timeout_q, timeout_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [WdWidth-1:0]     wd_q, wd_d;

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        r_d         = r_q;
        out_valid_d = out_valid_q;
        timeout_d   = timeout_q;
        cnt_d       = cnt_q;
        wd_d        = wd_q;
        case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    if (in_x_i != '0) begin
                        x_d     = in_x_i;
                        state_d = StStart;
                    end else begin
                        // 0 mod q is 0: answer directly without starting the reducer.
                        r_d         = '0;
                        out_valid_d = 1'b1;
                        state_d     = StHold;
                    end
                end
            end
            StStart: begin
                wd_d    = '0;
                state_d = StWait;
            end
            StWait: begin
                // A result arriving on the last watchdog cycle still counts.
                if (red_valid_i) begin
                    r_d         = red_result_i;
                    out_valid_d = 1'b1;
                    state_d     = StHold;
                end else if (wd_q == WdLast) begin
                    timeout_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    wd_d = wd_q + WdWidth'(1);
                end
            end
            StHold: begin
                if (out_ready_i) begin
                    out_valid_d = 1'b0;
                    cnt_d       = cnt_q + CNT_WIDTH'(1);
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK_pci_sys_clk_p or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            x_q         <= '0;
            r_q         <= '0;
            out_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            cnt_q       <= '0;
            wd_q        <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            r_q         <= r_d;
            out_valid_q <= out_valid_d;
            timeout_q   <= timeout_d;
            cnt_q       <= cnt_d;
            wd_q        <= wd_d;
        end
    end

    // The ready output is gated by reset so that it is low while reset is held.
    assign in_ready_o  = (state_q == StIdle) && !rst_i;
    assign red_start_o = (state_q == StStart);
    assign red_x_o     = x_q;
    assign red_q_o     = DATA_LENGTH'(MODULUS);
    assign red_q_bl_o  = DATA_LENGTH'(MODULUS_LENGTH);
    assign red_mu_o    = DATA_LENGTH'(MU);
    assign out_valid_o = out_valid_q;
    assign out_r_o     = r_q;
    assign timeout_o   = timeout_q;
    assign job_count_o = cnt_q;

endmodule

// File: tb/tb_barrett_ds_issuer.sv
module tb_barrett_ds_issuer;

    localparam int unsigned     DW = 64;
    localparam longint unsigned Q  = 64'd8380417;
    localparam int              TO = 256;
    localparam int unsigned     CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_x;
    logic          red_start;
    logic [DW-1:0] red_x;
    logic [DW-1:0] red_q;
    logic [DW-1:0] red_q_bl;
    logic [DW-1:0] red_mu;
    logic [DW-1:0] red_result;
    logic          red_valid;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_r;
    logic          timeout;
    logic [CW-1:0] job_count;

    int n_tests  = 0;
    int n_failed = 0;
    int exp_count;

    always #5 clk = ~clk;

    barrett_ds_issuer #(
        .DATA_LENGTH    (DW),
        .MODULUS        (8380417),
        .MODULUS_LENGTH (23),
        .MU             (8396807),
        .TIMEOUT_CYCLES (TO),
        .CNT_WIDTH      (CW)
    ) dut (
        .CLK_pci_sys_clk_p (clk),
        .rst_i             (rst),
        .in_valid_i        (in_valid),
        .in_ready_o        (in_ready),
        .in_x_i            (in_x),
        .red_start_o       (red_start),
        .red_x_o           (red_x),
        .red_q_o           (red_q),
        .red_q_bl_o        (red_q_bl),
        .red_mu_o          (red_mu),
        .red_result_i      (red_result),
        .red_valid_i       (red_valid),
        .out_valid_o       (out_valid),
        .out_ready_i       (out_ready),
        .out_r_o           (out_r),
        .timeout_o         (timeout),
        .job_count_o       (job_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rand64();
        logic [31:0] hi;
        logic [31:0] lo;
        hi = $urandom();
        lo = $urandom();
        return {hi, lo};
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_red_start"}, 64'(red_start), 64'd0);
        check({tag, "_red_x"}, red_x, 64'd0);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_out_r"}, out_r, 64'd0);
        check({tag, "_timeout"}, 64'(timeout), 64'd0);
        check({tag, "_job_count"}, 64'(job_count), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_values("reset");
        check("reset_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_reset_in_ready", 64'(in_ready), 64'd1);
        exp_count = 0;
        @(negedge clk);
    endtask

    // One job: the bench acts as the reducer and answers `delay` cycles after the
    // start pulse is seen (delay < 0: never answers, the watchdog must fire).
    task automatic run_job(input logic [63:0] x, input int delay, input int hold,
                           input bit spurious);
        int            k;
        int            starts;
        bit            started;
        bit            got_out;
        bit            back_idle;
        logic [63:0]   seen_x;
        logic [63:0]   exp_r;
        logic [CW-1:0] count_before;
        int            w;
        exp_r        = x % Q;
        count_before = job_count;
        in_x         = x;
        in_valid     = 1'b1;
        w            = 0;
        while (!in_ready && w < 10) begin
            @(negedge clk);
            w++;
        end
        check("in_ready_at_issue", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid  = 1'b0;
        in_x      = rand64();
        k         = 0;
        starts    = 0;
        started   = 1'b0;
        got_out   = 1'b0;
        back_idle = 1'b0;
        seen_x    = '0;
        for (int c = 0; c < TO + 20; c++) begin
            if (red_start) begin
                starts++;
                seen_x  = red_x;
                started = 1'b1;
                k       = 0;
            end else if (started) begin
                k++;
            end
            if (out_valid) begin
                got_out = 1'b1;
                break;
            end
            if (delay < 0 && started && k > 0 && in_ready) begin
                back_idle = 1'b1;
                break;
            end
            red_valid  = started && (k == delay);
            red_result = red_valid ? seen_x % Q : rand64();
            @(negedge clk);
        end
        red_valid = 1'b0;

        if (delay < 0) begin
            check("timeout_back_idle", 64'(back_idle), 64'd1);
            check("timeout_cycles", 64'(k), 64'(TO + 1));
            check("timeout_flag", 64'(timeout), 64'd1);
            check("timeout_no_output", 64'(out_valid), 64'd0);
            check("timeout_count_kept", 64'(job_count), 64'(count_before));
            check("timeout_starts", 64'(starts), 64'd1);
            return;
        end

        check("out_valid", 64'(got_out), 64'd1);
        check("result", out_r, exp_r);
        if (x == 0) begin
            check("zero_no_start", 64'(starts), 64'd0);
        end else begin
            check("start_pulses", 64'(starts), 64'd1);
            check("red_x", seen_x, x);
            check("latency", 64'(k), 64'(delay + 1));
        end

        for (int h = 0; h < hold; h++) begin
            out_ready  = 1'b0;
            red_valid  = spurious && (h == 3);
            red_result = ~exp_r;
            @(negedge clk);
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_result", out_r, exp_r);
            check("hold_in_ready", 64'(in_ready), 64'd0);
        end
        red_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        exp_count = (exp_count + 1) % (1 << CW);
        check("job_count", 64'(job_count), 64'(exp_count));
        check("out_valid_cleared", 64'(out_valid), 64'd0);
        check("ready_after_handshake", 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [63:0] x;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_x       = '0;
        red_result = '0;
        red_valid  = 1'b0;
        out_ready  = 1'b0;
        exp_count  = 0;
        repeat (3) @(negedge clk);
        check_reset_values("init");
        check("init_in_ready", 64'(in_ready), 64'd0);
        check("red_q", red_q, 64'd8380417);
        check("red_q_bl", red_q_bl, 64'd23);
        check("red_mu", red_mu, 64'd8396807);
        rst = 1'b0;
        #1;
        check("idle_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);

        run_job(64'h1000_0000, 5, 0, 1'b0);
        check("first_result_const", out_r, 64'h3FFE0);
        run_job(64'd0, 5, 0, 1'b0);

        x = rand64() | 64'd1;
        run_job(x, 7, 10, 1'b1);

        // Result on the very last watchdog cycle wins over the timeout.
        x = rand64() | 64'd1;
        run_job(x, TO, 0, 1'b0);
        check("late_result_no_timeout", 64'(timeout), 64'd0);

        // Reset while waiting on the reducer; the late result must be ignored.
        in_x     = rand64() | 64'd1;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("wait_reset_start", 64'(red_start), 64'd1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_values("wait_reset");
        @(negedge clk);
        rst        = 1'b0;
        exp_count  = 0;
        red_valid  = 1'b1;
        red_result = rand64();
        @(negedge clk);
        red_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("after_stale_valid");
        check("after_stale_in_ready", 64'(in_ready), 64'd1);

        x = rand64() | 64'd1;
        run_job(x, -1, 0, 1'b0);
        x = rand64() | 64'd1;
        run_job(x, 4, 2, 1'b0);
        check("timeout_sticky", 64'(timeout), 64'd1);

        do_reset();
        for (int j = 0; j < 17; j++) begin
            x = ($urandom_range(0, 4) == 0) ? 64'd0 : rand64();
            run_job(x, $urandom_range(1, 12), $urandom_range(0, 2), 1'b0);
        end
        check("count_wrap", 64'(job_count), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
